// File: rtl/alu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Package   : Definitions
// Purpose   : Shared types for the ALU controller: ALU opcode mnemonics,
//             controller state encoding, controller-only opcodes and the
//             result-source selector.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package Definitions;

    // Opcodes understood by the external datapath ALU (encodings 0..11)
    typedef enum logic [3:0] {
        NOP    = 4'd0,
        INC    = 4'd1,
        DEC    = 4'd2,
        CLB    = 4'd3,
        ADD    = 4'd4,
        SUB    = 4'd5,
        ORR    = 4'd6,
        AND    = 4'd7,
        LSH    = 4'd8,
        RXOR_7 = 4'd9,
        RXOR_8 = 4'd10,
        XOR    = 4'd11
    } op_mne;

    // Controller FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } ctrl_state_t;

    // Opcodes handled by the controller itself rather than the ALU
    localparam logic [3:0] LDI = 4'd12;
    localparam logic [3:0] MVA = 4'd13;
    localparam logic [3:0] MVR = 4'd14;
    localparam logic [3:0] HLT = 4'd15;

    // Source of the value captured into the result register in EXEC
    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_IMM = 2'd1,
        RES_RF  = 2'd2
    } res_sel_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
//------------------------------------------------------------------------------
// Module    : alu_ctrl_decode
// Purpose   : Purely combinational opcode decode: ALU operation, accumulator
//             write enable, zero-flag update, register-file write, halt and
//             result-source select.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_decode
    import Definitions::*;
(
    input  logic [3:0] opcode,
    output op_mne      alu_op,
    output logic       acc_we,
    output logic       flag_upd,
    output logic       rf_we,
    output logic       halt,
    output res_sel_t   res_sel
);

    // Map the 4-bit opcode onto control strobes; ALU opcodes share encodings
    always_comb begin
        alu_op   = NOP;
        acc_we   = 1'b0;
        flag_upd = 1'b0;
        rf_we    = 1'b0;
        halt     = 1'b0;
        res_sel  = RES_ALU;
        if (opcode <= 4'd11) begin
            alu_op   = op_mne'(opcode);
            flag_upd = 1'b1;
            // NOP refreshes the flag from the ALU but never touches Acc
            acc_we   = (opcode != 4'd0);
        end else begin
            case (opcode)
                LDI: begin
                    acc_we  = 1'b1;
                    res_sel = RES_IMM;
                end
                MVA: begin
                    acc_we  = 1'b1;
                    res_sel = RES_RF;
                end
                MVR:     rf_we = 1'b1;
                HLT:     halt  = 1'b1;
                default: halt  = 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl.sv
//------------------------------------------------------------------------------
// Module    : alu_ctrl
// Purpose   : Multi-cycle accumulator controller. Accepts one 9-bit
//             instruction per handshake, steps IDLE->DECODE->EXEC->WB, drives
//             an external ALU and register file, and parks in HALT on HLT.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl
    import Definitions::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [8:0]   Instr,
    input  logic         Instr_valid,
    output logic         Instr_ready,
    output op_mne        ALU_OP,
    output logic [W-1:0] Alu_A,
    output logic [W-1:0] Alu_B,
    input  logic [W-1:0] Alu_out,
    input  logic         Alu_zero,
    output logic [3:0]   Rf_rd_addr,
    input  logic [W-1:0] Rf_rd_data,
    output logic         Rf_wr_en,
    output logic [3:0]   Rf_wr_addr,
    output logic [W-1:0] Rf_wr_data,
    output logic         Zero_flag,
    output logic         Done,
    output logic         Halted
);

    ctrl_state_t  state;
    ctrl_state_t  next_state;
    logic [8:0]   instr_q;
    logic [W-1:0] acc;
    logic [W-1:0] result;
    logic         zero_q;

    op_mne        dec_op;
    logic         dec_acc_we;
    logic         dec_flag_upd;
    logic         dec_rf_we;
    logic         dec_halt;
    res_sel_t     dec_res_sel;

    // Decode always works from the latched instruction, never the live input
    alu_ctrl_decode u_decode (
        .opcode   (instr_q[8:5]),
        .alu_op   (dec_op),
        .acc_we   (dec_acc_we),
        .flag_upd (dec_flag_upd),
        .rf_we    (dec_rf_we),
        .halt     (dec_halt),
        .res_sel  (dec_res_sel)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fixed four-cycle sequence, HLT diverts to a sink state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Instr_valid) next_state = DECODE;
            DECODE:  next_state = dec_halt ? HALT : EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: strobes are pure functions of state and latched decode
    always_comb begin
        Instr_ready = (state == IDLE);
        Done        = (state == WB);
        Halted      = (state == HALT);
        ALU_OP      = (state == EXEC) ? dec_op : NOP;
        Rf_wr_en    = (state == WB) && dec_rf_we;
    end

    // Instruction latch, result capture, flag update and accumulator write-back
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_q <= '0;
            acc     <= '0;
            result  <= '0;
            zero_q  <= 1'b0;
        end else begin
            if ((state == IDLE) && Instr_valid) begin
                instr_q <= Instr;
            end
            if (state == EXEC) begin
                case (dec_res_sel)
                    RES_IMM: result <= W'(instr_q[4:0]);
                    RES_RF:  result <= Rf_rd_data;
                    default: result <= Alu_out;
                endcase
                if (dec_flag_upd) begin
                    zero_q <= Alu_zero;
                end
            end
            if ((state == WB) && dec_acc_we) begin
                acc <= result;
            end
        end
    end

    // The register address field is operand[3:0]; operand[4] only matters to LDI
    assign Rf_rd_addr = instr_q[3:0];
    assign Rf_wr_addr = instr_q[3:0];
    assign Rf_wr_data = acc;
    assign Alu_A      = acc;
    assign Alu_B      = Rf_rd_data;
    assign Zero_flag  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
//------------------------------------------------------------------------------
// Module    : tb_alu_ctrl
// Purpose   : Directed self-checking bench for alu_ctrl with a behavioural
//             ALU and register file attached.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl;
    import Definitions::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [8:0] Instr;
    logic       Instr_valid;
    logic       Instr_ready;
    op_mne      ALU_OP;
    logic [7:0] Alu_A, Alu_B, Alu_out, Rf_rd_data, Rf_wr_data;
    logic       Alu_zero, Rf_wr_en, Zero_flag, Done, Halted;
    logic [3:0] Rf_rd_addr, Rf_wr_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // observations recorded by exec_instr
    int         obs_done_cyc, obs_done_n, obs_ready_cyc, obs_wr_n, obs_op_stray;
    logic [3:0] obs_wr_addr;
    logic [7:0] obs_wr_data;
    op_mne      obs_exec_op;

    // register file preload port
    logic       pl_en;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] rf [16];

    always #5 Clk = ~Clk;

    alu_ctrl #(.W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Instr_valid(Instr_valid),
        .Instr_ready(Instr_ready), .ALU_OP(ALU_OP), .Alu_A(Alu_A), .Alu_B(Alu_B),
        .Alu_out(Alu_out), .Alu_zero(Alu_zero), .Rf_rd_addr(Rf_rd_addr),
        .Rf_rd_data(Rf_rd_data), .Rf_wr_en(Rf_wr_en), .Rf_wr_addr(Rf_wr_addr),
        .Rf_wr_data(Rf_wr_data), .Zero_flag(Zero_flag), .Done(Done), .Halted(Halted)
    );

    // behavioural ALU
    always_comb begin
        case (ALU_OP)
            INC:     Alu_out = Alu_A + 8'd1;
            DEC:     Alu_out = Alu_A - 8'd1;
            CLB:     Alu_out = 8'd0;
            ADD:     Alu_out = Alu_A + Alu_B;
            SUB:     Alu_out = Alu_A - Alu_B;
            ORR:     Alu_out = Alu_A | Alu_B;
            AND:     Alu_out = Alu_A & Alu_B;
            LSH:     Alu_out = Alu_A << 1;
            RXOR_7:  Alu_out = {7'd0, ^Alu_A[6:0]};
            RXOR_8:  Alu_out = {7'd0, ^Alu_A};
            XOR:     Alu_out = Alu_A ^ Alu_B;
            default: Alu_out = Alu_A;
        endcase
        Alu_zero = (Alu_out == 8'd0);
    end

    // behavioural register file: async read, sync write
    assign Rf_rd_data = rf[Rf_rd_addr];
    always @(posedge Clk) begin
        if (Rf_wr_en) rf[Rf_wr_addr] <= Rf_wr_data;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    // Offer one instruction from IDLE (called just after a falling edge) and record behaviour
    task automatic exec_instr(input logic [3:0] op, input logic [4:0] opnd);
        obs_done_cyc = -1; obs_done_n = 0; obs_ready_cyc = -1;
        obs_wr_n = 0; obs_op_stray = 0; obs_wr_addr = '0; obs_wr_data = '0;
        obs_exec_op = NOP;
        Instr = {op, opnd};
        Instr_valid = 1'b1;
        @(posedge Clk);
        #1;
        Instr_valid = 1'b0;
        Instr = 9'h1EF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            if (Done) begin
                obs_done_n++;
                if (obs_done_cyc < 0) obs_done_cyc = c;
            end
            if (Rf_wr_en) begin
                obs_wr_n++;
                obs_wr_addr = Rf_wr_addr;
                obs_wr_data = Rf_wr_data;
            end
            if (c == 2) obs_exec_op = ALU_OP;
            else if (ALU_OP != NOP) obs_op_stray++;
            if (Instr_ready) begin
                obs_ready_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge Clk);
        n_tests++;
        if ({Done, Halted, Rf_wr_en, Zero_flag} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000", {Done, Halted, Rf_wr_en, Zero_flag});
        end
        n_tests++;
        if (ALU_OP !== NOP || Rf_rd_addr !== 4'd0 || Rf_wr_addr !== 4'd0) begin
            n_fail++; $display("FAIL reset_addr_op: got op=%0d rd=%0d wr=%0d want 0/0/0", ALU_OP, Rf_rd_addr, Rf_wr_addr);
        end
        n_tests++;
        if (Alu_A !== 8'h00) begin
            n_fail++; $display("FAIL reset_acc: got %h want 00", Alu_A);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (Instr_ready !== 1'b1 || Done !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got ready=%b done=%b want 1/0", Instr_ready, Done);
        end
    endtask

    task automatic test_ldi_inc();
        exec_instr(LDI, 5'd5);
        n_tests++;
        if (obs_done_cyc !== 3 || obs_done_n !== 1 || obs_ready_cyc !== 4) begin
            n_fail++; $display("FAIL ldi_timing: got done@%0d x%0d ready@%0d want 3 x1 4", obs_done_cyc, obs_done_n, obs_ready_cyc);
        end
        n_tests++;
        if (Alu_A !== 8'd5 || obs_op_stray !== 0) begin
            n_fail++; $display("FAIL ldi_acc: got acc=%0d stray=%0d want 5/0", Alu_A, obs_op_stray);
        end
        exec_instr(4'd1, 5'd0);
        n_tests++;
        if (Alu_A !== 8'd6 || Zero_flag !== 1'b0) begin
            n_fail++; $display("FAIL inc_acc: got acc=%0d z=%b want 6/0", Alu_A, Zero_flag);
        end
        n_tests++;
        if (obs_exec_op !== INC || obs_done_cyc !== 3 || obs_ready_cyc !== 4) begin
            n_fail++; $display("FAIL inc_exec: got op=%0d done@%0d ready@%0d want 1/3/4", obs_exec_op, obs_done_cyc, obs_ready_cyc);
        end
    endtask

    task automatic test_zero_flag();
        exec_instr(LDI, 5'd1);
        exec_instr(4'd2, 5'd0);
        n_tests++;
        if (Alu_A !== 8'd0 || Zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL dec_zero: got acc=%0d z=%b want 0/1", Alu_A, Zero_flag);
        end
        exec_instr(LDI, 5'd0);
        n_tests++;
        if (Alu_A !== 8'd0 || Zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL ldi0_flag: got acc=%0d z=%b want 0/1", Alu_A, Zero_flag);
        end
        exec_instr(LDI, 5'd31);
        n_tests++;
        if (Alu_A !== 8'd31 || Zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL ldi31: got acc=%0d z=%b want 31/1", Alu_A, Zero_flag);
        end
        exec_instr(4'd0, 5'd0);
        n_tests++;
        if (Alu_A !== 8'd31 || Zero_flag !== 1'b0 || obs_done_cyc !== 3) begin
            n_fail++; $display("FAIL nop_flag: got acc=%0d z=%b done@%0d want 31/0/3", Alu_A, Zero_flag, obs_done_cyc);
        end
    endtask

    task automatic test_add_mvr();
        exec_instr(LDI, 5'd1);
        exec_instr(4'd4, 5'h13);
        n_tests++;
        if (Alu_A !== 8'h80 || Zero_flag !== 1'b0 || obs_exec_op !== ADD) begin
            n_fail++; $display("FAIL add_r3: got acc=%h z=%b op=%0d want 80/0/4", Alu_A, Zero_flag, obs_exec_op);
        end
        n_tests++;
        if (obs_wr_n !== 0) begin
            n_fail++; $display("FAIL add_no_write: got %0d writes want 0", obs_wr_n);
        end
        exec_instr(MVR, 5'd5);
        n_tests++;
        if (obs_wr_n !== 1 || obs_wr_addr !== 4'd5 || obs_wr_data !== 8'h80) begin
            n_fail++; $display("FAIL mvr_write: got n=%0d addr=%0d data=%h want 1/5/80", obs_wr_n, obs_wr_addr, obs_wr_data);
        end
        n_tests++;
        if (rf[5] !== 8'h80 || Alu_A !== 8'h80 || obs_done_cyc !== 3) begin
            n_fail++; $display("FAIL mvr_after: got rf5=%h acc=%h done@%0d want 80/80/3", rf[5], Alu_A, obs_done_cyc);
        end
        exec_instr(MVA, 5'd3);
        n_tests++;
        if (Alu_A !== 8'h7F || Zero_flag !== 1'b0) begin
            n_fail++; $display("FAIL mva_r3: got acc=%h z=%b want 7f/0", Alu_A, Zero_flag);
        end
    endtask

    task automatic test_back_to_back();
        int n_ready;
        int n_done;
        n_ready = 0;
        n_done  = 0;
        exec_instr(LDI, 5'd10);
        Instr = {4'd1, 5'd0};
        Instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (Instr_ready) n_ready++;
            if (Done) n_done++;
            @(posedge Clk);
            @(negedge Clk);
        end
        Instr_valid = 1'b0;
        n_tests++;
        if (n_ready !== 4 || n_done !== 4) begin
            n_fail++; $display("FAIL b2b_rate: got ready=%0d done=%0d want 4/4", n_ready, n_done);
        end
        n_tests++;
        if (Alu_A !== 8'd14 || Instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_acc: got acc=%0d ready=%b want 14/1", Alu_A, Instr_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n_bad;
        n_bad = 0;
        exec_instr(LDI, 5'd1);
        Instr = {4'd4, 5'd3};
        Instr_valid = 1'b1;
        @(posedge Clk);
        #1;
        Instr_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        n_tests++;
        if (ALU_OP !== ADD) begin
            n_fail++; $display("FAIL midrst_exec_op: got %0d want 4", ALU_OP);
        end
        Reset_n = 1'b0;
        #1;
        n_tests++;
        if (Alu_A !== 8'd0 || Done !== 1'b0 || Rf_wr_en !== 1'b0 || ALU_OP !== NOP || Instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_async: got acc=%0d done=%b wr=%b op=%0d ready=%b want 0/0/0/0/1",
                               Alu_A, Done, Rf_wr_en, ALU_OP, Instr_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            if (Done || Rf_wr_en) n_bad++;
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (Instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_ready: got %b want 1", Instr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (Done || Rf_wr_en) n_bad++;
            @(negedge Clk);
        end
        n_tests++;
        if (n_bad !== 0 || Alu_A !== 8'd0 || rf[3] !== 8'h7F) begin
            n_fail++; $display("FAIL midrst_after: got bad=%0d acc=%0d rf3=%h want 0/0/7f", n_bad, Alu_A, rf[3]);
        end
    endtask

    task automatic test_halt();
        int n_bad;
        n_bad = 0;
        exec_instr(HLT, 5'd0);
        n_tests++;
        if (obs_done_n !== 0 || obs_ready_cyc !== -1 || Halted !== 1'b1) begin
            n_fail++; $display("FAIL hlt_enter: got done=%0d ready@%0d halted=%b want 0/-1/1", obs_done_n, obs_ready_cyc, Halted);
        end
        Instr = {LDI, 5'd7};
        Instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Halted !== 1'b1 || Instr_ready !== 1'b0 || Done !== 1'b0) n_bad++;
        end
        Instr_valid = 1'b0;
        n_tests++;
        if (n_bad !== 0 || Alu_A !== 8'd0) begin
            n_fail++; $display("FAIL hlt_hold: got bad=%0d acc=%0d want 0/0", n_bad, Alu_A);
        end
        Reset_n = 1'b0;
        #1;
        n_tests++;
        if (Halted !== 1'b0) begin
            n_fail++; $display("FAIL hlt_reset: got halted=%b want 0", Halted);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        exec_instr(LDI, 5'd7);
        n_tests++;
        if (Alu_A !== 8'd7 || obs_done_cyc !== 3 || Halted !== 1'b0) begin
            n_fail++; $display("FAIL hlt_recover: got acc=%0d done@%0d halted=%b want 7/3/0", Alu_A, obs_done_cyc, Halted);
        end
    endtask

    // Watchdog so a stuck DUT still ends the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n = 1'b0;
        Instr = '0;
        Instr_valid = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            pl_en = 1'b1;
            pl_addr = 4'(i);
            pl_data = (i == 3) ? 8'h7F : 8'h00;
        end
        @(negedge Clk);
        pl_en = 1'b0;
        test_reset();
        test_ldi_inc();
        test_zero_flag();
        test_add_mvr();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, datapath width.
REQ-002 SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Instr  input  9  instruction: [8:5] opcode, [4:0] operand.
REQ-005 SHALL have port Instr_valid  input  1  instruction offered.
REQ-006 SHALL have port Instr_ready  output  1  block accepts instruction.
REQ-007 SHALL have port ALU_OP  output  op_mne  opcode to datapath ALU.
REQ-008 SHALL have ports Alu_A, Alu_B  output  W  ALU operands: Alu_A = accumulator, Alu_B = Rf_rd_data.
REQ-009 SHALL have ports Alu_out  input  W and Alu_zero  input  1  ALU result and zero flag.
REQ-010 SHALL have ports Rf_rd_addr  output  4 and Rf_rd_data  input  W  asynchronous-read register file port.
REQ-011 SHALL have ports Rf_wr_en  output  1, Rf_wr_addr  output  4, Rf_wr_data  output  W  register file write port.
REQ-012 SHALL have ports Zero_flag  output  1, Done  output  1 (one-cycle retire pulse), Halted  output  1.

Function
REQ-013 SHALL hold an internal W-bit accumulator Acc and a registered Zero_flag.
REQ-014 SHALL implement FSM states IDLE, DECODE, EXEC, WB, HALT.
REQ-015 SHALL assert Instr_ready only in IDLE; handshake = Instr_valid & Instr_ready on a rising edge, Instr latched then, IDLE->DECODE.
REQ-016 SHALL ignore Instr_valid outside IDLE; latched instruction stays stable until retire.
REQ-017 DECODE: drive Rf_rd_addr = operand[3:0]; next state EXEC, except opcode 15 -> HALT.
REQ-018 EXEC: keep Rf_rd_addr; for opcodes 0..11 drive ALU_OP = op_mne value of same encoding (NOP,INC,DEC,CLB,ADD,SUB,ORR,AND,LSH,RXOR_7,RXOR_8,XOR); at EXEC end capture Alu_out into result register and Alu_zero into Zero_flag; next WB.
REQ-019 ALU_OP SHALL equal NOP in every state other than EXEC.
REQ-020 Opcode 12 (LDI): result = zero-extended operand[4:0]; Zero_flag unchanged.
REQ-021 Opcode 13 (MVA): result = Rf_rd_data; Zero_flag unchanged.
REQ-022 Opcode 14 (MVR): Rf_wr_en=1, Rf_wr_addr=operand[3:0], Rf_wr_data=Acc during WB; Acc unchanged.
REQ-023 WB: opcodes 1..13 load result into Acc at WB end; opcode 0 leaves Acc unchanged but updates Zero_flag; Done=1 for exactly WB cycle; next IDLE.
REQ-024 Latency: handshake edge T; DECODE T+1, EXEC T+2, WB T+3, Instr_ready high again at T+4; max throughput 1 instruction / 4 cycles.
REQ-025 Rf_wr_en SHALL be high only in WB of opcode 14.
REQ-026 HALT: Halted=1, Instr_ready=0, Done=0, held until Reset_n low; opcode 15 produces no Done.
REQ-027 Arithmetic wraps modulo 2^W (ALU-defined); operand[4] ignored for opcodes other than 12.

Reset
REQ-028 Reset_n low SHALL asynchronously force state IDLE, Acc=0, Zero_flag=0, result=0, Done=0, Halted=0, Rf_wr_en=0, ALU_OP=NOP, Rf_rd_addr=0, Rf_wr_addr=0.
REQ-029 Reset mid-instruction SHALL abort it with no register file write and no Done; Instr_ready=1 on first edge after release.

Structure
REQ-030 Controller state enum and opcode constants (LDI=12, MVA=13, MVR=14, HLT=15) SHALL live in package Definitions beside op_mne.
REQ-031 Combinational decode (opcode -> ALU_OP, acc-write, flag-update, rf-write, halt) SHALL be sub-module alu_ctrl_decode.

Verification
REQ-032 LDI 5 then INC -> Acc=6, Zero_flag=0, Done at T+3 of each.
REQ-033 LDI 1, DEC -> Acc=0, Zero_flag=1; then LDI 0 -> Zero_flag stays 1.
REQ-034 rf[3]=0x7F preloaded, LDI 1, ADD r3 -> Acc=0x80; MVR r5 -> Rf_wr_en one cycle, addr 5, data 0x80.
REQ-035 Instr_valid held high continuously -> accepts exactly one instruction per 4 cycles, Instr_ready low in DECODE/EXEC/WB.
REQ-036 Reset_n low during EXEC of ADD -> no Rf_wr_en, no Done, Acc=0, IDLE after release.
REQ-037 HLT -> Halted=1, Instr_ready=0 for 20 cycles despite Instr_valid=1; reset clears Halted.
